mem_arbiter: RTL and testbench

Shares the single data port of the dual-port memory (RAM side: address, 4-bit write mask, write data, 1-cycle registered read data) between two requesters.
- m0: CPU load/store unit.
- m1: debug/DMA loader, e.g. a UART program loader.
The instruction port is untouched. The block sits between the requesters and the memory's data port. It does round-robin or fixed-priority arbitration, supports a lock for bursts, and guards against starvation.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb_wait_cnt.sv | 28 ++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-port arbiter between the CPU LSU (m0) and the debug/DMA loader (m1).
package mem_arb_pkg;

    localparam int         ADDR_W    = 32;
    localparam logic [3:0] MASK_READ = 4'b0000;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e;
    typedef enum logic       {P0, P1}           port_e;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Per-port starvation counter: counts cycles a requester is refused and flags when its grant must be forced.
module mem_arb_wait_cnt #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    input  logic blocked,
    output logic force_gnt
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

    logic [7:0] cnt;

    // Saturates at LIMIT so a port refused while unguarded is served as soon as the guard applies.
    always_ff @(posedge clk) begin
        if (reset || !req || gnt) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign force_gnt = req && blocked && (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the memory data port with lock ownership and starvation guard.
// Optional grant/force statistics outputs are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit          PRIO0    = 1'b1,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_data
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [15:0]       stat_force
`endif
);

    arb_state_e state, state_nxt;
    port_e      last_gnt;
    logic       gnt0, gnt1;
    logic       block0, block1;
    logic       force0, force1;

    // m1 is also guarded in IDLE when fixed priority could starve it.
    assign block0 = (state == OWN1);
    assign block1 = (state == OWN0) || ((state == IDLE) && PRIO0);

    mem_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait0 (
        .clk       (clk),
        .reset     (reset),
        .req       (m0_req),
        .gnt       (gnt0),
        .blocked   (block0),
        .force_gnt (force0)
    );

    mem_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait1 (
        .clk       (clk),
        .reset     (reset),
        .req       (m1_req),
        .gnt       (gnt1),
        .blocked   (block1),
        .force_gnt (force1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= P1;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            state     <= state_nxt;
            if (gnt0) begin
                last_gnt <= P0;
            end else if (gnt1) begin
                last_gnt <= P1;
            end
            m0_rvalid <= gnt0 && (m0_wmask == MASK_READ);
            m1_rvalid <= gnt1 && (m1_wmask == MASK_READ);
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (force1) begin
                        gnt1 = 1'b1;
                    end else if (m0_req && m1_req) begin
                        if (PRIO0 || (last_gnt == P1)) gnt0 = 1'b1;
                        else                           gnt1 = 1'b1;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                    // A forced grant never confers ownership.
                    if (gnt0 && m0_lock)                 state_nxt = OWN0;
                    else if (gnt1 && m1_lock && !force1) state_nxt = OWN1;
                end
                OWN0: begin
                    if (force1) begin
                        gnt1      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        gnt0 = m0_req;
                        if (!m0_lock) state_nxt = IDLE;
                    end
                end
                OWN1: begin
                    if (force0) begin
                        gnt0      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        gnt1 = m1_req;
                        if (!m1_lock) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = MASK_READ;
        if (gnt0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wmask = m0_wmask;
        end else if (gnt1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wmask = m1_wmask;
        end
    end

    assign m0_gnt   = gnt0;
    assign m1_gnt   = gnt1;
    assign m0_rdata = m0_rvalid ? mem_data : '0;
    assign m1_rdata = m1_rvalid ? mem_data : '0;

`ifdef MEM_ARB_STATS_EN
    logic forced;
    assign forced = (gnt0 && force0) || (gnt1 && force1);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_gnt0  <= '0;
            stat_gnt1  <= '0;
            stat_force <= '0;
        end else begin
            if (gnt0 && (stat_gnt0 != '1))    stat_gnt0  <= stat_gnt0 + 32'd1;
            if (gnt1 && (stat_gnt1 != '1))    stat_gnt1  <= stat_gnt1 + 32'd1;
            if (forced && (stat_force != '1)) stat_force <= stat_force + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (round-robin, MAX_WAIT=16) with a per-cycle reference model and literal checks.
module tb_mem_arbiter;

    localparam bit PRIO0    = 1'b0;
    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_data;
    logic [3:0]  mem_wmask;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          owner, last, w0, w1;
    bit          pend0, pend1;
    logic [31:0] pdata0, pdata1;
    logic [31:0] ref_mem [256];

    // Memory behind the data port
    logic [31:0] ram [256];
    bit          ram_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.PRIO0(PRIO0), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wmask  (m0_wmask),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wmask  (m1_wmask),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_data  (mem_data)
    );

    function automatic logic [31:0] init_word(int unsigned i);
        if (i == 4) return 32'h1234_5678;
        if (i == 8) return 32'h1122_3344;
        return 32'hA500_0000 | i;
    endfunction

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_data <= ram[mem_addr[9:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Checks every observable output against the arbitration rules, then advances the model past the next edge.
    task automatic model_cmp();
        bit          f0, f1, g0, g1;
        logic [31:0] ea, ed;
        logic [3:0]  em;
        f0 = 0; f1 = 0; g0 = 0; g1 = 0;
        if (!reset) begin
            f1 = m1_req && (w1 >= MAX_WAIT - 1) && (owner == 0 || (owner < 0 && PRIO0));
            f0 = m0_req && (w0 >= MAX_WAIT - 1) && (owner == 1);
            if (f1)                     g1 = 1;
            else if (f0)                g0 = 1;
            else if (owner == 0)        g0 = m0_req;
            else if (owner == 1)        g1 = m1_req;
            else if (m0_req && m1_req) begin
                if (PRIO0 || last == 1) g0 = 1;
                else                    g1 = 1;
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
        ea = g0 ? m0_addr  : g1 ? m1_addr  : 32'd0;
        ed = g0 ? m0_wdata : g1 ? m1_wdata : 32'd0;
        em = g0 ? m0_wmask : g1 ? m1_wmask : 4'd0;
        check("m0_gnt",    m0_gnt,    g0);
        check("m1_gnt",    m1_gnt,    g1);
        check("mem_addr",  mem_addr,  ea);
        check("mem_wdata", mem_wdata, ed);
        check("mem_wmask", mem_wmask, em);
        check("m0_rvalid", m0_rvalid, pend0);
        check("m1_rvalid", m1_rvalid, pend1);
        check("m0_rdata",  m0_rdata,  pend0 ? pdata0 : 32'd0);
        check("m1_rdata",  m1_rdata,  pend1 ? pdata1 : 32'd0);

        if (reset) begin
            owner = -1; last = 1; w0 = 0; w1 = 0; pend0 = 0; pend1 = 0;
        end else begin
            pend0 = g0 && (m0_wmask == 4'd0);
            pend1 = g1 && (m1_wmask == 4'd0);
            if (pend0) pdata0 = ref_mem[m0_addr[9:2]];
            if (pend1) pdata1 = ref_mem[m1_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (g0 && m0_wmask[b]) ref_mem[m0_addr[9:2]][8*b +: 8] = m0_wdata[8*b +: 8];
                if (g1 && m1_wmask[b]) ref_mem[m1_addr[9:2]][8*b +: 8] = m1_wdata[8*b +: 8];
            end
            w0 = (m0_req && !g0) ? ((w0 + 1 > MAX_WAIT - 1) ? MAX_WAIT - 1 : w0 + 1) : 0;
            w1 = (m1_req && !g1) ? ((w1 + 1 > MAX_WAIT - 1) ? MAX_WAIT - 1 : w1 + 1) : 0;
            if (f0 || f1)                    owner = -1;
            else if (owner < 0 && g0 && m0_lock) owner = 0;
            else if (owner < 0 && g1 && m1_lock) owner = 1;
            else if (owner == 0 && !m0_lock) owner = -1;
            else if (owner == 1 && !m1_lock) owner = -1;
            if (g0) last = 0;
            if (g1) last = 1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m0_req = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
        m1_req = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1;
        settle();
        adv();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        owner = -1; last = 1; w0 = 0; w1 = 0;
        pend0 = 0; pend1 = 0; pdata0 = '0; pdata1 = '0;
        idle_in();
        reset = 1;
        adv();

        // Requests during reset must not be granted
        m0_req = 1; m1_req = 1; m0_wmask = 4'hF;
        settle();
        check("rst_gnts",   {30'd0, m0_gnt, m1_gnt}, 32'd0);
        check("rst_wmask",  mem_wmask, 32'd0);
        check("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        adv();
        reset = 0;
        idle_in();

        // Single read
        m0_req = 1; m0_addr = 32'h10;
        settle();
        check("s1_gnt", m0_gnt, 1);
        adv();
        idle_in();
        settle();
        check("s1_rvalid", m0_rvalid, 1);
        check("s1_rdata",  m0_rdata, 32'h1234_5678);
        check("s1_m1rv",   m1_rvalid, 0);
        adv();

        // Round-robin contention
        do_reset();
        m0_req = 1; m0_addr = 32'h100;
        m1_req = 1; m1_addr = 32'h200;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("s2_g0", m0_gnt, (k % 2) == 0);
            check("s2_g1", m1_gnt, (k % 2) == 1);
            if (k > 0) begin
                check("s2_rv0", m0_rvalid, ((k - 1) % 2) == 0);
                check("s2_rd1", m1_rdata, ((k - 1) % 2) == 1 ? 32'hA500_0080 : 32'd0);
            end
            adv();
        end
        idle_in();
        settle();
        adv();

        // Byte write then read-back
        m1_req = 1; m1_addr = 32'h20; m1_wdata = 32'hAABB_CCDD; m1_wmask = 4'b0010;
        settle();
        check("s3_wgnt",  m1_gnt, 1);
        check("s3_wmask", mem_wmask, 32'h2);
        adv();
        m1_wmask = 4'b0000;
        settle();
        check("s3_norv", m1_rvalid, 0);
        adv();
        idle_in();
        settle();
        check("s3_rv",    m1_rvalid, 1);
        check("s3_rdata", m1_rdata, 32'h1122_CC44);
        adv();

        // Lock held by m0 with m1 waiting: forced grant on the 16th cycle
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h200;
        for (int k = 0; k < 16; k++) begin
            settle();
            check("s4_g0", m0_gnt, k != 15);
            check("s4_g1", m1_gnt, k == 15);
            adv();
        end
        m1_req = 0;
        settle();
        check("s4_reown", m0_gnt, 1);
        adv();
        m0_lock = 0;
        settle();
        adv();
        idle_in();
        settle();
        adv();

        // Lock release: owner keeps the release-cycle grant, then m1
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h20;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) m0_lock = 0;
            settle();
            check("s5_g0", m0_gnt, k < 4);
            check("s5_g1", m1_gnt, k == 4);
            adv();
        end
        idle_in();
        settle();
        adv();

        // Reset right after an m1 read grant
        m1_req = 1; m1_addr = 32'h20;
        settle();
        check("s6_gnt", m1_gnt, 1);
        adv();
        idle_in();
        reset = 1;
        settle();
        check("s6_rstgnt", m1_gnt, 0);
        adv();
        reset = 0;
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h20;
        settle();
        check("s6_rv1",   m1_rvalid, 0);
        check("s6_fresh", {30'd0, m0_gnt, m1_gnt}, 32'd2);
        adv();
        idle_in();
        settle();
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
